// File: rtl/fetch_dec_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fetch_dec_queue: circular instruction buffer between fetch and decode,  |
// | compacting FW-wide fetch beats and presenting DW oldest entries.        |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef InstWidth
`define InstWidth 32
`endif

module fetch_dec_queue #(
  parameter int ADDR  = `AddrWidth,
  parameter int INST  = `InstWidth,
  parameter int FW    = 2,
  parameter int DW    = 2,
  parameter int DEPTH = 8,
  parameter int CNT   = $clog2(DEPTH + 1),
  parameter int TK    = $clog2(DW + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FW-1:0]      in_e_,
  input  logic [FW*ADDR-1:0] in_pc,
  input  logic [FW*INST-1:0] in_inst,
  input  logic               dec_flush_,
  input  logic               dec_stop,
  output logic               dec_stall,
  output logic [DW-1:0]      out_e_,
  output logic [DW*ADDR-1:0] out_pc,
  output logic [DW*INST-1:0] out_inst,
  input  logic [TK-1:0]      dec_take,
  output logic [CNT-1:0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CNT:0] DEPTH_C = (CNT + 1)'(DEPTH);
  localparam logic [CNT:0] FW_C    = (CNT + 1)'(FW);

  logic [CNT-1:0] count_q, count_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;

  logic [ADDR-1:0] mem_pc   [DEPTH];
  logic [INST-1:0] mem_inst [DEPTH];

  logic           accept;
  logic [CNT-1:0] n_in;
  logic [PW-1:0]  ofs [FW];
  logic [CNT-1:0] vis;
  logic [CNT-1:0] take_ext;
  logic [CNT-1:0] n_out;

  // Conservative: free space is judged from registered count only.
  assign dec_stall = (DEPTH_C - {1'b0, count_q}) < FW_C;
  assign accept    = dec_flush_ & ~dec_stall;
  assign count     = count_q;

  // Each valid slot lands after all valid slots below it, closing holes.
  always_comb begin
    n_in = '0;
    for (int i = 0; i < FW; i++) begin
      ofs[i] = PW'(n_in);
      if (!in_e_[i]) n_in = n_in + CNT'(1);
    end
  end

  always_comb begin
    if (dec_stop || !dec_flush_) begin
      vis = '0;
    end else if (count_q > CNT'(DW)) begin
      vis = CNT'(DW);
    end else begin
      vis = count_q;
    end
  end

  assign take_ext = CNT'(dec_take);
  assign n_out    = (take_ext < vis) ? take_ext : vis;

  always_comb begin
    out_e_   = '1;
    out_pc   = '0;
    out_inst = '0;
    for (int j = 0; j < DW; j++) begin
      if (CNT'(j) < vis) begin
        out_e_[j]                = 1'b0;
        out_pc[j*ADDR +: ADDR]   = mem_pc[rd_ptr_q + PW'(j)];
        out_inst[j*INST +: INST] = mem_inst[rd_ptr_q + PW'(j)];
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (!dec_flush_) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(n_out);
      if (accept) begin
        wr_ptr_d = wr_ptr_q + PW'(n_in);
        count_d  = count_q + n_in - n_out;
      end else begin
        count_d  = count_q - n_out;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FW; i++) begin
      if (accept && !in_e_[i]) begin
        mem_pc[wr_ptr_q + ofs[i]]   <= in_pc[i*ADDR +: ADDR];
        mem_inst[wr_ptr_q + ofs[i]] <= in_inst[i*INST +: INST];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_dec_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_fetch_dec_queue: directed scoreboard bench for fetch_dec_queue.      |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_fetch_dec_queue;

  localparam int ADDR  = 32;
  localparam int INST  = 32;
  localparam int FW    = 2;
  localparam int DW    = 2;
  localparam int DEPTH = 8;
  localparam int CNT   = 4;
  localparam int TK    = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [FW-1:0]      in_e_;
  logic [FW*ADDR-1:0] in_pc;
  logic [FW*INST-1:0] in_inst;
  logic               dec_flush_;
  logic               dec_stop;
  logic               dec_stall;
  logic [DW-1:0]      out_e_;
  logic [DW*ADDR-1:0] out_pc;
  logic [DW*INST-1:0] out_inst;
  logic [TK-1:0]      dec_take;
  logic [CNT-1:0]     count;

  fetch_dec_queue #(
    .ADDR(ADDR), .INST(INST), .FW(FW), .DW(DW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .in_e_(in_e_), .in_pc(in_pc), .in_inst(in_inst),
    .dec_flush_(dec_flush_), .dec_stop(dec_stop), .dec_stall(dec_stall),
    .out_e_(out_e_), .out_pc(out_pc), .out_inst(out_inst),
    .dec_take(dec_take), .count(count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb [$];
  int          pops = 0;
  logic [31:0] last_pop = '0;
  int          idx;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check presented state against the queue model, update model.
  task automatic cycle(input logic [1:0] ie, input logic [31:0] p0, input logic [31:0] p1,
                       input logic [1:0] take, input logic stop, input logic fl_n);
    int          vis;
    int          nout;
    logic        m_stall;
    logic [1:0]  exp_e;
    logic [63:0] exp_pc;
    logic [63:0] exp_inst;
    in_e_      = ie;
    in_pc      = {p1, p0};
    in_inst    = {~p1, ~p0};
    dec_take   = take;
    dec_stop   = stop;
    dec_flush_ = fl_n;
    #1;
    m_stall  = (DEPTH - sb.size()) < FW;
    vis      = (stop || !fl_n) ? 0 : ((sb.size() < DW) ? sb.size() : DW);
    exp_e    = '1;
    exp_pc   = '0;
    exp_inst = '0;
    for (int j = 0; j < vis; j++) begin
      exp_e[j]            = 1'b0;
      exp_pc[j*32 +: 32]  = sb[j];
      exp_inst[j*32 +: 32] = ~sb[j];
    end
    chk("count", 64'(count), 64'(sb.size()));
    chk("dec_stall", 64'(dec_stall), 64'(m_stall));
    chk("out_e_", 64'(out_e_), 64'(exp_e));
    chk("out_pc", out_pc, exp_pc);
    chk("out_inst", out_inst, exp_inst);
    nout = (int'(take) < vis) ? int'(take) : vis;
    for (int n = 0; n < nout; n++) begin
      last_pop = sb.pop_front();
      pops++;
    end
    if (!fl_n) begin
      sb.delete();
    end else if (!m_stall) begin
      if (!ie[0]) sb.push_back(p0);
      if (!ie[1]) sb.push_back(p1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    in_e_      = '1;
    in_pc      = '0;
    in_inst    = '0;
    dec_flush_ = 1'b1;
    dec_stop   = 1'b0;
    dec_take   = '0;

    // Reset state
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_stall", 64'(dec_stall), 64'd0);
    chk("rst_out_e", 64'(out_e_), 64'h3);
    chk("rst_out_pc", out_pc, 64'd0);
    #10;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_count", 64'(count), 64'd0);
    chk("post_rst_out_e", 64'(out_e_), 64'h3);

    // Basic enqueue, partial then full beat
    cycle(2'b10, 32'h100, 32'hDEAD_BEEF, 2'd0, 1'b0, 1'b1);
    cycle(2'b00, 32'h104, 32'h108, 2'd0, 1'b0, 1'b1);
    chk("t2_count", 64'(count), 64'd3);
    chk("t2_out_pc", out_pc, {32'h104, 32'h100});
    chk("t2_out_e", 64'(out_e_), 64'h0);
    cycle(2'b11, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1);
    cycle(2'b11, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);

    // Hole compaction
    cycle(2'b01, 32'hDEAD, 32'h20C, 2'd0, 1'b0, 1'b1);
    chk("t3_count", 64'(count), 64'd1);
    chk("t3_out_e", 64'(out_e_), 64'h2);
    chk("t3_pc0", 64'(out_pc[31:0]), 64'h20C);
    cycle(2'b11, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);

    // Full / stall, dropped fifth beat, release after dequeue
    for (int b = 0; b < 4; b++)
      cycle(2'b00, 32'h300 + 32'(8*b), 32'h304 + 32'(8*b), 2'd0, 1'b0, 1'b1);
    chk("t4_stall", 64'(dec_stall), 64'd1);
    chk("t4_count", 64'(count), 64'd8);
    cycle(2'b00, 32'h340, 32'h344, 2'd0, 1'b0, 1'b1);
    chk("t4_drop_count", 64'(count), 64'd8);
    cycle(2'b11, 32'h0, 32'h0, 2'd2, 1'b0, 1'b1);
    chk("t4_deq_count", 64'(count), 64'd6);
    chk("t4_unstall", 64'(dec_stall), 64'd0);
    cycle(2'b11, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);

    // Wrap-around streaming; take=3 saturates to the visible count
    pops = 0;
    idx  = 0;
    for (int g = 0; g < 100; g++) begin
      if (idx >= 20 && sb.size() == 0) break;
      if (idx < 20 && (DEPTH - sb.size()) >= FW) begin
        cycle(2'b00, 32'(idx*4), 32'((idx+1)*4), (g % 3 == 2) ? 2'd3 : 2'd2, 1'b0, 1'b1);
        idx += 2;
      end else begin
        cycle(2'b11, 32'h0, 32'h0, 2'd2, 1'b0, 1'b1);
      end
    end
    chk("t5_pops", 64'(pops), 64'd20);
    chk("t5_last_pc", 64'(last_pop), 64'h4C);
    chk("t5_drained", 64'(count), 64'd0);

    // Stop holds output while enqueue continues; flush discards everything
    cycle(2'b00, 32'h400, 32'h404, 2'd0, 1'b0, 1'b1);
    cycle(2'b00, 32'h408, 32'h40C, 2'd0, 1'b0, 1'b1);
    cycle(2'b10, 32'h410, 32'hDEAD, 2'd0, 1'b0, 1'b1);
    chk("t6_count5", 64'(count), 64'd5);
    cycle(2'b00, 32'h414, 32'h418, 2'd2, 1'b1, 1'b1);
    chk("t6_count7", 64'(count), 64'd7);
    cycle(2'b00, 32'h41C, 32'h420, 2'd2, 1'b1, 1'b0);
    chk("t6_flush_count", 64'(count), 64'd0);
    chk("t6_flush_out_e", 64'(out_e_), 64'h3);
    cycle(2'b11, 32'h0, 32'h0, 2'd2, 1'b0, 1'b1);

    // Asynchronous reset mid-operation
    cycle(2'b00, 32'h500, 32'h504, 2'd0, 1'b0, 1'b1);
    cycle(2'b00, 32'h508, 32'h50C, 2'd0, 1'b0, 1'b1);
    in_e_ = '1;
    #3;
    reset = 1'b1;
    #1;
    chk("t7_async_count", 64'(count), 64'd0);
    chk("t7_async_out_e", 64'(out_e_), 64'h3);
    chk("t7_async_stall", 64'(dec_stall), 64'd0);
    sb.delete();
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    cycle(2'b11, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_dec_queue.md
# fetch_dec_queue

Parametrised instruction buffer between the fetch and decode stages. It generalises the single-instruction fetch/decode handshake to FW-wide fetch beats and DW-wide decode reads, with a DEPTH-entry circular buffer in between. It supports per-slot valid with hole compaction, pipeline flush, decode stop and a registered-state stall back to fetch.

## Interface
- ADDR, `AddrWidth: PC width.
- INST, `InstWidth: instruction width.
- FW, 2: instructions per fetch beat (1..4).
- DW, 2: instructions presented to decode per cycle (1..DEPTH).
- DEPTH, 8: buffer entries; power of two, DEPTH >= 2*FW.
- CNT, $clog2(DEPTH+1): count width (derived).
- TK, $clog2(DW+1): take-field width (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_e_  in  FW  per-slot instruction enable, active-low; slot i is bit i.
- in_pc  in  FW*ADDR  slot i at [i*ADDR +: ADDR].
- in_inst  in  FW*INST  slot i at [i*INST +: INST].
- dec_flush_  in  1  active-low flush.
- dec_stop  in  1  hold decode output (mispredicted branch pending commit).
- dec_stall  out  1  to fetch; beat not accepted this cycle.
- out_e_  out  DW  per-slot output enable, active-low.
- out_pc  out  DW*ADDR  oldest-first instruction PCs.
- out_inst  out  DW*INST  oldest-first instructions.
- dec_take  in  TK  number of presented instructions decode consumes this cycle.
- count  out  CNT  current occupancy (debug/perf).

## Operation
- State: mem[DEPTH] of {pc, inst}; rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH; count is CNT bits.
- Stall: dec_stall = (DEPTH - count) < FW. It depends on registered count only, with no input-to-output combinational path. The conservative rule ignores same-cycle dequeue.
- Enqueue when dec_stall=0 and dec_flush_=1:
  - Valid slots (in_e_[i]=0) are compacted in ascending i order into wr_ptr, wr_ptr+1, … (mod DEPTH).
  - n_in = popcount(~in_e_).
  - Acceptance is atomic: all valid slots of the beat are written, or none.
  - With dec_stall=1 the beat is dropped. Fetch must hold the beat until dec_stall=0.
- Present:
  - vis = 0 if dec_stop=1 or dec_flush_=0; otherwise min(count, DW).
  - Slot j<vis: out_e_[j]=0, data=mem[rd_ptr+j].
  - Slot j>=vis: out_e_[j]=1, out_pc/out_inst slice = 0.
- Dequeue: n_out = min(dec_take, vis). Out-of-range dec_take saturates and is not an error. rd_ptr += n_out.
- Update: count_next = count + n_in(accepted) - n_out. Enqueue and dequeue in the same cycle are both applied.
- Flush (dec_flush_=0): at the next edge rd_ptr=wr_ptr=count=0. Same-cycle enqueue and dequeue are discarded. Flush has priority over stop.
- dec_stop=1: outputs are masked and no dequeue happens; enqueue continues normally.
- mem contents are not reset; only pointers and count are reset.

## Timing
- Reset (async assert, sync release): rd_ptr=wr_ptr=count=0, dec_stall=0, out_e_=all 1, out_pc=out_inst=0.
- Enqueue-to-output latency: 1 cycle. A beat accepted at edge k is visible at out_* after edge k.
- Dequeue takes effect at the edge; the next-oldest entries are presented in the following cycle.
- dec_stall changes only after clock edges (or reset).
- Flush: out_e_ are forced high combinationally while dec_flush_=0; the queue is empty from the next cycle on.
- Reset mid-operation: all contents are discarded immediately; reset does not wait for a clock.

## Test plan
All scenarios use FW=2, DW=2, DEPTH=8.
1. Reset asserted, then released -> out_e_=2'b11, count=0, dec_stall=0, out_pc=0.
2. Enqueue in_e_=2'b10 with pc0=0x100, then in_e_=2'b00 with pcs 0x104/0x108, dec_take=0 -> count=3; out_pc slot0=0x100, slot1=0x104; out_e_=2'b00.
3. Hole compaction: from empty, in_e_=2'b01 with slot1 pc=0x20C -> next cycle slot0 pc=0x20C, out_e_=2'b10, count=1.
4. Full/stall:
   - Four beats of 2 with dec_take=0 -> dec_stall=1 once count=7 or 8.
   - The fifth beat is dropped (count stays 8).
   - dec_take=2 -> count=6, dec_stall=0 the next cycle.
5. Wrap-around: stream 20 sequential PCs from 0x0 (step 4) with dec_take=2 each cycle -> decode sees 0x0..0x4C strictly in order across pointer wrap, with no loss or duplication.
6. Flush and stop:
   - With count=5, dec_stop=1 -> out_e_=2'b11 and count stays 5 while a beat enqueues (count=7).
   - Then dec_flush_=0 with dec_stop=1 and a valid beat -> next cycle count=0, out_e_=2'b11, and the beat is not stored.
